// File: rtl/fpu_ret_merge_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : fpu_ret_pkg
//  Purpose  : Shared constants and entry typedef for the FPU retire merge
//             buffer.
//  Revision : 1.0 - initial release
// ============================================================================
package fpu_ret_pkg;

  // Retire word width produced by each FPU lane.
  localparam int RET_W         = 14;
  // Lane index width; lanes are numbered 1..6, so 0 never appears in a valid entry.
  localparam int LANE_W        = 3;
  // Number of retire lanes feeding the buffer.
  localparam int FPU_RET_LANES = 6;

  // One buffered entry: the originating lane tag on top of the retire word.
  typedef struct packed {
    logic [LANE_W-1:0] lane;
    logic [RET_W-1:0]  ret;
  } ret_entry_t;

endpackage : fpu_ret_pkg
`default_nettype wire

// File: rtl/fpu_ret_merge_if.sv
`default_nettype none
// ============================================================================
//  Module   : fpu_ret_merge_if
//  Purpose  : Bundles the six retire lanes, the two-slot drain port and the
//             status outputs of the retire merge buffer.
//  Revision : 1.0 - initial release
// ============================================================================
interface fpu_ret_merge_if #(
  parameter int DEPTH = 16,
  parameter int RET_W = 14
);

  localparam int CNT_W = $clog2(DEPTH) + 1;

  // Retire lanes from the FPU cluster.
  logic [RET_W-1:0] u1_ret, u2_ret, u3_ret, u4_ret, u5_ret, u6_ret;
  logic             u1_ret_en, u2_ret_en, u3_ret_en, u4_ret_en, u5_ret_en, u6_ret_en;

  // Two-slot drain port toward the ROB write side.
  logic             out0_valid, out1_valid;
  logic [RET_W+2:0] out0_data, out1_data;
  logic             out_ready;

  // Status back toward issue.
  logic             ret_stall;
  logic             overflow;
  logic [CNT_W-1:0] count;

  // Producer/consumer side (FPU lanes plus ROB drain).
  modport master (
    output u1_ret, u2_ret, u3_ret, u4_ret, u5_ret, u6_ret,
    output u1_ret_en, u2_ret_en, u3_ret_en, u4_ret_en, u5_ret_en, u6_ret_en,
    output out_ready,
    input  out0_valid, out1_valid, out0_data, out1_data,
    input  ret_stall, overflow, count
  );

  // Buffer side.
  modport slave (
    input  u1_ret, u2_ret, u3_ret, u4_ret, u5_ret, u6_ret,
    input  u1_ret_en, u2_ret_en, u3_ret_en, u4_ret_en, u5_ret_en, u6_ret_en,
    input  out_ready,
    output out0_valid, out1_valid, out0_data, out1_data,
    output ret_stall, overflow, count
  );

endinterface : fpu_ret_merge_if
`default_nettype wire

// File: rtl/fpu_ret_merge_compact6.sv
`default_nettype none
// ============================================================================
//  Module   : fpu_ret_compact6
//  Purpose  : Prefix popcount over the six lane enables. Gives each lane its
//             write offset from wr_ptr, admits lanes in ascending order up to
//             the free-space limit and flags any lane that had to be dropped.
//  Revision : 1.0 - initial release
// ============================================================================
module fpu_ret_compact6
  import fpu_ret_pkg::*;
(
  input  logic [FPU_RET_LANES-1:0]      en_i,     // bit 0 = u1
  input  logic [2:0]                    limit_i,  // lanes admissible this cycle (0..6)
  output logic [FPU_RET_LANES-1:0][2:0] off_o,    // slot offset from wr_ptr per lane
  output logic [FPU_RET_LANES-1:0]      acc_o,    // lane admitted
  output logic [2:0]                    nwr_o,    // number of admitted lanes
  output logic                          drop_o    // an enabled lane was refused
);

  logic [2:0] run;

  // Walk lanes in order; the running admitted count is each lane's offset.
  always_comb begin
    run    = 3'd0;
    off_o  = '0;
    acc_o  = '0;
    drop_o = 1'b0;
    for (int i = 0; i < FPU_RET_LANES; i++) begin
      off_o[i] = run;
      if (en_i[i]) begin
        if (run < limit_i) begin
          acc_o[i] = 1'b1;
          run      = run + 3'd1;
        end else begin
          drop_o = 1'b1;
        end
      end
    end
    nwr_o = run;
  end

endmodule : fpu_ret_compact6
`default_nettype wire

// File: rtl/fpu_ret_merge.sv
`default_nettype none
// ============================================================================
//  Module   : fpu_ret_merge
//  Purpose  : Completion-merge FIFO behind the six FPU retire lanes. Packs up
//             to six tagged retire words per cycle, drains up to two per
//             cycle and raises ret_stall while a full burst might not fit.
//  Revision : 1.0 - initial release
// ============================================================================
module fpu_ret_merge
  import fpu_ret_pkg::LANE_W;
  import fpu_ret_pkg::FPU_RET_LANES;
#(
  parameter int DEPTH = 16,
  parameter int RET_W = fpu_ret_pkg::RET_W
) (
  input  logic            clk,
  input  logic            rst,
  fpu_ret_merge_if.slave  ret_if
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int ENT_W = LANE_W + RET_W;

  logic [FPU_RET_LANES-1:0]      w_en;
  logic [RET_W-1:0]              w_ret [FPU_RET_LANES];
  logic [FPU_RET_LANES-1:0][2:0] w_off;
  logic [FPU_RET_LANES-1:0]      w_acc;
  logic [2:0]                    w_nwr;
  logic                          w_drop;
  logic [1:0]                    w_nrd;
  logic [CNT_W-1:0]              w_free;
  logic [2:0]                    w_limit;
  logic                          w_v0, w_v1;
  logic [PTR_W-1:0]              w_rd1;

  logic [ENT_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q,  count_d;
  logic             overflow_q, overflow_d;

  assign w_en = {ret_if.u6_ret_en, ret_if.u5_ret_en, ret_if.u4_ret_en,
                 ret_if.u3_ret_en, ret_if.u2_ret_en, ret_if.u1_ret_en};
  assign w_ret[0] = ret_if.u1_ret;
  assign w_ret[1] = ret_if.u2_ret;
  assign w_ret[2] = ret_if.u3_ret;
  assign w_ret[3] = ret_if.u4_ret;
  assign w_ret[4] = ret_if.u5_ret;
  assign w_ret[5] = ret_if.u6_ret;

  // Slot validity comes only from the registered occupancy.
  assign w_v0  = (count_q != '0);
  assign w_v1  = (count_q >= CNT_W'(2));
  assign w_rd1 = rd_ptr_q + PTR_W'(1);

  // Entries consumed this cycle: every valid slot when the consumer is ready.
  always_comb begin
    w_nrd = 2'd0;
    if (ret_if.out_ready) begin
      w_nrd = {1'b0, w_v0} + {1'b0, w_v1};
    end
  end

  // Space freed by this cycle's reads is reusable by this cycle's writes;
  // the limit only bites when upstream ignores ret_stall.
  assign w_free  = CNT_W'(DEPTH) - count_q + CNT_W'(w_nrd);
  assign w_limit = (w_free >= CNT_W'(FPU_RET_LANES)) ? 3'(FPU_RET_LANES) : w_free[2:0];

  fpu_ret_compact6 u_compact (
    .en_i    (w_en),
    .limit_i (w_limit),
    .off_o   (w_off),
    .acc_o   (w_acc),
    .nwr_o   (w_nwr),
    .drop_o  (w_drop)
  );

  // Next pointer, occupancy and sticky overflow state.
  always_comb begin
    wr_ptr_d   = wr_ptr_q + PTR_W'(w_nwr);
    rd_ptr_d   = rd_ptr_q + PTR_W'(w_nrd);
    count_d    = count_q + CNT_W'(w_nwr) - CNT_W'(w_nrd);
    overflow_d = overflow_q | w_drop;
  end

  // Control state register; reset wins over any same-cycle traffic.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  // Storage write: admitted lanes land at consecutive slots, wrapping mod DEPTH.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < FPU_RET_LANES; i++) begin
        if (w_acc[i]) begin
          mem_q[wr_ptr_q + PTR_W'(w_off[i])] <= {LANE_W'(i + 1), w_ret[i]};
        end
      end
    end
  end

  assign ret_if.out0_valid = w_v0;
  assign ret_if.out1_valid = w_v1;
  assign ret_if.out0_data  = w_v0 ? mem_q[rd_ptr_q] : '0;
  assign ret_if.out1_data  = w_v1 ? mem_q[w_rd1]    : '0;
  assign ret_if.ret_stall  = (count_q > CNT_W'(DEPTH - FPU_RET_LANES));
  assign ret_if.overflow   = overflow_q;
  assign ret_if.count      = count_q;

endmodule : fpu_ret_merge
`default_nettype wire

// File: tb/tb_fpu_ret_merge.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fpu_ret_merge
//  Purpose  : Scoreboard bench for fpu_ret_merge: a queue holds the entries
//             the buffer must hold, in order, and every cycle the DUT outputs
//             are compared against its head.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_fpu_ret_merge;
  import fpu_ret_pkg::*;

  localparam int DEPTH = 16;
  localparam int TW    = 14;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fpu_ret_merge_if #(.DEPTH(DEPTH), .RET_W(TW)) bus ();

  fpu_ret_merge #(.DEPTH(DEPTH), .RET_W(TW)) dut (
    .clk    (clk),
    .rst    (rst),
    .ret_if (bus)
  );

  logic [16:0] sb_q [$];
  logic        m_ovf;
  int          n_chk = 0;
  int          n_err = 0;

  // Single comparison point: counts and reports.
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Compare every output against the scoreboard state.
  task automatic check_state();
    int          sz;
    logic [16:0] d0, d1;
    sz = sb_q.size();
    d0 = (sz >= 1) ? sb_q[0] : 17'h0;
    d1 = (sz >= 2) ? sb_q[1] : 17'h0;
    chk("count",      32'(bus.count),      32'(sz));
    chk("out0_valid", 32'(bus.out0_valid), 32'(sz >= 1));
    chk("out1_valid", 32'(bus.out1_valid), 32'(sz >= 2));
    chk("out0_data",  32'(bus.out0_data),  32'(d0));
    chk("out1_data",  32'(bus.out1_data),  32'(d1));
    chk("ret_stall",  32'(bus.ret_stall),  32'(sz > DEPTH - 6));
    chk("overflow",   32'(bus.overflow),   32'(m_ovf));
  endtask

  task automatic set_lanes(input logic [5:0] en, input logic [5:0][13:0] r);
    {bus.u6_ret_en, bus.u5_ret_en, bus.u4_ret_en,
     bus.u3_ret_en, bus.u2_ret_en, bus.u1_ret_en} = en;
    bus.u1_ret = r[0]; bus.u2_ret = r[1]; bus.u3_ret = r[2];
    bus.u4_ret = r[3]; bus.u5_ret = r[4]; bus.u6_ret = r[5];
  endtask

  // One clock: check, drive, update the scoreboard, advance.
  task automatic cycle(input logic [5:0] en, input logic [5:0][13:0] r, input logic ready);
    int         sz, nrd, free, n;
    ret_entry_t e;
    check_state();
    set_lanes(en, r);
    bus.out_ready = ready;
    sz   = sb_q.size();
    nrd  = ready ? ((sz >= 2) ? 2 : sz) : 0;
    free = DEPTH - sz + nrd;
    for (int k = 0; k < nrd; k++) void'(sb_q.pop_front());
    n = 0;
    for (int i = 0; i < 6; i++) begin
      if (en[i]) begin
        if (n < free) begin
          e.lane = 3'(i + 1);
          e.ret  = r[i];
          sb_q.push_back(e);
          n++;
        end else begin
          m_ovf = 1'b1;
        end
      end
    end
    @(posedge clk); #1;
    set_lanes(6'h00, '0);
    bus.out_ready = 1'b0;
  endtask

  task automatic do_reset(input int ncyc);
    rst = 1'b1;
    set_lanes(6'h00, '0);
    bus.out_ready = 1'b0;
    repeat (ncyc) begin @(posedge clk); #1; end
    rst = 1'b0;
    sb_q.delete();
    m_ovf = 1'b0;
  endtask

  function automatic logic [5:0][13:0] vals(input logic [13:0] base);
    logic [5:0][13:0] v;
    for (int i = 0; i < 6; i++) v[i] = base + 14'(i);
    return v;
  endfunction

  logic [5:0][13:0] rv;
  logic [5:0]       ren;

  initial begin
    rst   = 1'b1;
    m_ovf = 1'b0;
    set_lanes(6'h00, '0);
    bus.out_ready = 1'b0;

    // Reset then idle with the consumer ready.
    do_reset(2);
    chk("rst_count", 32'(bus.count), 32'd0);
    chk("rst_stall", 32'(bus.ret_stall), 32'd0);
    chk("rst_out0",  32'(bus.out0_data), 32'd0);
    repeat (3) cycle(6'h00, '0, 1'b1);

    // Compaction order: u2, u5, u6.
    rv = '0; rv[1] = 14'h011; rv[4] = 14'h022; rv[5] = 14'h033;
    cycle(6'b110010, rv, 1'b0);
    chk("cmp_count", 32'(bus.count),     32'd3);
    chk("cmp_out0",  32'(bus.out0_data), 32'({3'd2, 14'h011}));
    chk("cmp_out1",  32'(bus.out1_data), 32'({3'd5, 14'h022}));
    cycle(6'h00, '0, 1'b1);
    chk("cmp_out0b", 32'(bus.out0_data),  32'({3'd6, 14'h033}));
    chk("cmp_v1b",   32'(bus.out1_valid), 32'd0);
    chk("cmp_cnt1",  32'(bus.count),      32'd1);
    cycle(6'h00, '0, 1'b1);

    // Full burst, stall, then a violating burst.
    do_reset(1);
    cycle(6'h3F, vals(14'h040), 1'b0);
    chk("fb_cnt6",   32'(bus.count),     32'd6);
    chk("fb_stall0", 32'(bus.ret_stall), 32'd0);
    cycle(6'h3F, vals(14'h050), 1'b0);
    chk("fb_cnt12",  32'(bus.count),     32'd12);
    chk("fb_stall1", 32'(bus.ret_stall), 32'd1);
    cycle(6'h3F, vals(14'h060), 1'b0);
    chk("fb_cnt16",  32'(bus.count),     32'd16);
    chk("fb_ovf",    32'(bus.overflow),  32'd1);
    repeat (9) cycle(6'h00, '0, 1'b1);

    // Simultaneous read and write.
    do_reset(1);
    cycle(6'h0F, vals(14'h100), 1'b0);
    cycle(6'b000111, vals(14'h110), 1'b1);
    chk("rw_count", 32'(bus.count),     32'd5);
    chk("rw_out0",  32'(bus.out0_data), 32'({3'd3, 14'h102}));
    chk("rw_out1",  32'(bus.out1_data), 32'({3'd4, 14'h103}));
    repeat (3) cycle(6'h00, '0, 1'b1);

    // Wrap-around: move both pointers to 14, then a full burst.
    do_reset(1);
    cycle(6'h3F, vals(14'h180), 1'b0);
    cycle(6'h3F, vals(14'h190), 1'b0);
    cycle(6'h03, vals(14'h1A0), 1'b0);
    repeat (7) cycle(6'h00, '0, 1'b1);
    chk("wr_empty", 32'(bus.count), 32'd0);
    cycle(6'h3F, vals(14'h200), 1'b0);
    chk("wr_out0", 32'(bus.out0_data), 32'({3'd1, 14'h200}));
    chk("wr_out1", 32'(bus.out1_data), 32'({3'd2, 14'h201}));
    cycle(6'h00, '0, 1'b1);
    chk("wr_out0b", 32'(bus.out0_data), 32'({3'd3, 14'h202}));
    cycle(6'h00, '0, 1'b1);
    chk("wr_out1c", 32'(bus.out1_data), 32'({3'd6, 14'h205}));
    cycle(6'h00, '0, 1'b1);

    // Random traffic; upstream mostly honours the stall.
    for (int t = 0; t < 300; t++) begin
      for (int i = 0; i < 6; i++) rv[i] = 14'($urandom);
      ren = 6'($urandom);
      if (bus.ret_stall && ($urandom_range(0, 9) != 0)) ren = 6'h00;
      cycle(ren, rv, ($urandom_range(0, 2) != 0));
    end

    // Reset mid-operation with count 9 and overflow set.
    do_reset(1);
    cycle(6'h3F, vals(14'h300), 1'b0);
    cycle(6'h3F, vals(14'h310), 1'b0);
    cycle(6'h3F, vals(14'h320), 1'b0);
    repeat (4) cycle(6'h00, '0, 1'b1);
    cycle(6'h01, vals(14'h330), 1'b0);
    chk("mr_cnt9", 32'(bus.count),    32'd9);
    chk("mr_ovf1", 32'(bus.overflow), 32'd1);
    rst = 1'b1;
    set_lanes(6'h3F, vals(14'h340));
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    set_lanes(6'h00, '0);
    bus.out_ready = 1'b0;
    sb_q.delete();
    m_ovf = 1'b0;
    chk("mr_cnt0", 32'(bus.count),      32'd0);
    chk("mr_ovf0", 32'(bus.overflow),   32'd0);
    chk("mr_v0",   32'(bus.out0_valid), 32'd0);
    cycle(6'h00, '0, 1'b1);
    check_state();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end

endmodule : tb_fpu_ret_merge
`default_nettype wire
